// File: rtl/cmd_deserializer.sv
// Serial-to-parallel capture for the SD CMD line: shifts one bit per enabled clock,
// MSB first, and raises a sticky complete flag once framesize bits are held.
module cmd_deserializer #(
  parameter int WIDTH = 136,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  input  logic [CNT_W-1:0] framesize,
  output logic [WIDTH-1:0] out,
  output logic             complete
);

  typedef enum logic {
    S_SHIFT = 1'b0,
    S_DONE  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] fs_eff;
  logic [WIDTH-1:0] out_q, out_d;

  // Frames longer than the register clamp to its capacity.
  function automatic logic [CNT_W-1:0] sat_framesize(input logic [CNT_W-1:0] fs);
    logic [CNT_W-1:0] res;
    if (int'(fs) > WIDTH) res = CNT_W'(WIDTH);
    else                  res = fs;
    return res;
  endfunction

  assign fs_eff  = sat_framesize(framesize);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    if (state_q == S_SHIFT && enable) begin
      // A zero-length frame completes without consuming a bit.
      if (fs_eff == '0) begin
        state_d = S_DONE;
      end else begin
        out_d = {out_q[WIDTH-2:0], in};
        cnt_d = cnt_inc;
        if (cnt_inc == fs_eff) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SHIFT;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out      = out_q;
  assign complete = (state_q == S_DONE);

endmodule

// File: tb/tb_cmd_deserializer.sv
// Bench for cmd_deserializer: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_cmd_deserializer;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         in;
  logic [7:0]   framesize;
  logic [135:0] out;
  logic         complete;

  int n_pass  = 0;
  int n_total = 0;

  cmd_deserializer #(.WIDTH(136), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in        (in),
    .framesize (framesize),
    .out       (out),
    .complete  (complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   fs;
    logic [135:0] pat;
    int           nbits;
    int           exp_edges;
    logic [135:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    in     = 1'b0;
    #2;
    reset  = 1'b0;
  endtask

  // Sends pat MSB-first with enable held high; returns the edge on which complete rose (0 = never).
  task automatic run_frame(input logic [7:0] fs, input logic [135:0] pat, input int nbits,
                           output int edges);
    bit got;
    got   = 1'b0;
    edges = 0;
    framesize = fs;
    for (int e = 1; e <= 300 && !got; e++) begin
      enable = 1'b1;
      in     = (e <= nbits) ? pat[nbits-e] : 1'($urandom);
      @(posedge clk); #1;
      if (complete) begin
        got   = 1'b1;
        edges = e;
      end
    end
  endtask

  initial begin
    int           edges;
    logic [135:0] ones;
    logic [47:0]  v48;
    logic [7:0]   fs;
    int           eff;
    bit           mdone;
    bit           en, b;
    int           extra;
    bit           q[$];
    logic [135:0] exp_out;
    bit           got;
    int           bi;

    ones = '1;
    vecs[0] = '{fs: 8'd12,  pat: 136'hAAB,          nbits: 12,  exp_edges: 12,  exp_out: 136'hAAB};
    vecs[1] = '{fs: 8'd48,  pat: 136'h123456789ABC, nbits: 48,  exp_edges: 48,  exp_out: 136'h123456789ABC};
    vecs[2] = '{fs: 8'd136, pat: ones,              nbits: 136, exp_edges: 136, exp_out: ones};
    vecs[3] = '{fs: 8'd200, pat: ones,              nbits: 136, exp_edges: 136, exp_out: ones};
    vecs[4] = '{fs: 8'd0,   pat: 136'h0,            nbits: 0,   exp_edges: 1,   exp_out: 136'h0};
    vecs[5] = '{fs: 8'd1,   pat: 136'h1,            nbits: 1,   exp_edges: 1,   exp_out: 136'h1};

    reset = 1'b1; enable = 1'b1; in = 1'b1; framesize = 8'd12;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", out, 136'h0);
    check("reset_complete", complete, 1'b0);

    // Table vectors, each followed by 20 cycles of activity that must not disturb DONE.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_frame(vecs[v].fs, vecs[v].pat, vecs[v].nbits, edges);
      check($sformatf("vec%0d_edges", v), 136'(edges), 136'(vecs[v].exp_edges));
      check($sformatf("vec%0d_out", v), out, vecs[v].exp_out);
      for (int c = 0; c < 20; c++) begin
        enable = 1'b1;
        in     = c[0];
        @(posedge clk); #1;
      end
      check($sformatf("vec%0d_hold_out", v), out, vecs[v].exp_out);
      check($sformatf("vec%0d_hold_complete", v), complete, 1'b1);
    end

    // 48-bit frame with a 3-cycle enable gap after bit 24.
    do_reset();
    v48 = {16'($urandom), 32'($urandom)};
    framesize = 8'd48;
    got = 1'b0; edges = 0;
    for (int t = 1; t <= 100 && !got; t++) begin
      en = (t <= 24) || (t > 27);
      bi = (t <= 24) ? t - 1 : t - 4;
      enable = en;
      in     = en ? v48[47-bi] : 1'($urandom);
      @(posedge clk); #1;
      if (complete) begin
        got = 1'b1;
        edges = t;
      end
    end
    check("gap_edges", 136'(edges), 136'd51);
    check("gap_out", out, {88'h0, v48});

    // Asynchronous reset mid-frame, then a fresh frame.
    do_reset();
    framesize = 8'd12;
    for (int e = 0; e < 5; e++) begin
      enable = 1'b1; in = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_reset_out", out, 136'h1F);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_out", out, 136'h0);
    check("async_reset_complete", complete, 1'b0);
    reset = 1'b0;
    run_frame(8'd12, 136'hC35, 12, edges);
    check("after_reset_edges", 136'(edges), 136'd12);
    check("after_reset_out", out, 136'hC35);

    // Randomized frames with random enable gaps against the queue model.
    for (int f = 0; f < 8; f++) begin
      do_reset();
      fs = (f == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      framesize = fs;
      eff = (int'(fs) > 136) ? 136 : int'(fs);
      q.delete();
      mdone = 1'b0;
      extra = 0;
      for (int c = 0; c < 800 && extra < 5; c++) begin
        en = ($urandom_range(0, 3) != 0);
        b  = 1'($urandom);
        enable = en;
        in     = b;
        @(posedge clk); #1;
        if (en && !mdone) begin
          if (eff == 0) mdone = 1'b1;
          else begin
            q.push_back(b);
            if (q.size() == eff) mdone = 1'b1;
          end
        end
        // First captured bit sits at position size-1, last at position 0.
        exp_out = '0;
        for (int k = 0; k < q.size(); k++) exp_out[q.size()-1-k] = q[k];
        check($sformatf("rnd%0d_complete", f), complete, mdone);
        check($sformatf("rnd%0d_out", f), out, exp_out);
        if (mdone) extra++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
